// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the push-button front end.
// Idle (released) raw level, default debounce width, fixed channel roles.
package debounce_pkg;

    localparam int DB_BITS_DEF = 11;
    localparam int BTN_INC     = 0;
    localparam int BTN_DEC     = 1;

    function automatic logic idle_level(input bit active_low);
        return active_low ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// One button channel: 2-FF synchroniser, stability counter, debounced level, press pulse.
// Latency: level 2**(DB_BITS-1)+2 edges after first sample, press pulse one edge later.
// No backpressure: the press pulse is a single-cycle strobe.
module button_debouncer
    import debounce_pkg::*;
#(
    parameter int DB_BITS    = DB_BITS_DEF,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic n_reset,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press
);

    logic               s1_q, s2_q;
    logic [DB_BITS-1:0] db_cnt_q, db_cnt_d;
    logic               level_q, level_d;
    logic               level_prev_q;
    logic               press_q, press_d;
    logic               stable;

    // MSB set means the synchronised input has not moved for 2**(DB_BITS-1) cycles.
    assign stable = db_cnt_q[DB_BITS-1];

    always_comb begin
        db_cnt_d = db_cnt_q;
        level_d  = level_q;
        press_d  = level_q & ~level_prev_q;
        if (s1_q != s2_q) begin
            db_cnt_d = '0;
        end else if (!stable) begin
            db_cnt_d = db_cnt_q + DB_BITS'(1);
        end
        if (stable) begin
            level_d = ACTIVE_LOW ? ~s2_q : s2_q;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            s1_q         <= idle_level(ACTIVE_LOW);
            s2_q         <= idle_level(ACTIVE_LOW);
            db_cnt_q     <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            press_q      <= 1'b0;
        end else begin
            s1_q         <= btn_in;
            s2_q         <= s1_q;
            db_cnt_q     <= db_cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_q;
            press_q      <= press_d;
        end
    end

    assign btn_level = level_q;
    assign btn_press = press_q;

endmodule

// File: rtl/debounced_selector_counter.sv
// N-channel debounced buttons driving a bounded selector (ch0 up, ch1 down, others pulse-only).
// Latency: count/wrap_evt change one edge after the registered press pulse.
// No backpressure: outputs are free-running levels and single-cycle strobes.
module debounced_selector_counter
    import debounce_pkg::*;
#(
    parameter int NUM_BTN    = 2,
    parameter int DB_BITS    = DB_BITS_DEF,
    parameter int CNT_MIN    = 1,
    parameter int CNT_MAX    = 2,
    parameter int CNT_W      = $clog2(CNT_MAX + 1),
    parameter bit WRAP       = 1'b1,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic               clk,
    input  logic               n_reset,
    input  logic [NUM_BTN-1:0] btn_in,
    input  logic               enable,
    input  logic               clear,
    output logic [CNT_W-1:0]   count,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic               wrap_evt
);

    localparam logic [CNT_W-1:0] MIN_V = CNT_W'(CNT_MIN);
    localparam logic [CNT_W-1:0] MAX_V = CNT_W'(CNT_MAX);

    logic [NUM_BTN-1:0] press_w;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               wrap_q, wrap_d;
    logic               inc, dec;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        button_debouncer #(
            .DB_BITS    (DB_BITS),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_db (
            .clk       (clk),
            .n_reset   (n_reset),
            .btn_in    (btn_in[i]),
            .btn_level (btn_level[i]),
            .btn_press (press_w[i])
        );
    end

    assign inc = press_w[BTN_INC];
    assign dec = press_w[BTN_DEC];

    // Bounds are compared before stepping so the count never leaves [MIN, MAX].
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (clear) begin
            count_d = MIN_V;
        end else if (enable && (inc ^ dec)) begin
            if (inc) begin
                if (count_q == MAX_V) begin
                    if (WRAP) begin
                        count_d = MIN_V;
                        wrap_d  = 1'b1;
                    end
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end else begin
                if (count_q == MIN_V) begin
                    if (WRAP) begin
                        count_d = MAX_V;
                        wrap_d  = 1'b1;
                    end
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            count_q <= MIN_V;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count     = count_q;
    assign wrap_evt  = wrap_q;
    assign btn_press = press_w;

endmodule
